covariance_predict: RTL and testbench
=====================================

COVARIANCE_PREDICT -- requirements
Module: covariance_predict

Interface
REQ-001 Parameter N, default 32, signed fixed-point word width.
REQ-002 Parameter Q, default 18, fractional bits; one = 2**Q.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port start  input  1  request to compute one covariance prediction.
REQ-006 Port F  input  16*N  signed Jacobian, 4x4; element [r][c] at bits (4r+c)*N +: N.
REQ-007 Port P_in  input  16*N  signed prior covariance, same packing as F.
REQ-008 Port Qn_diag  input  4*N  signed process-noise diagonal; element i at bits i*N +: N.
REQ-009 Port P_out  output  16*N  registered predicted covariance, same packing as F.
REQ-010 Port busy  output  1  high while a computation is in progress.
REQ-011 Port done  output  1  one-cycle pulse when P_out holds a new result.
REQ-012 Port ovf  output  1  sticky flag, high if any element saturated or wrapped in the current or last computation.

Function
REQ-013 The block SHALL compute P_out = F*P_in*F^T + diag(Qn_diag) in Q-format, using exactly one multiplier.
REQ-014 FSM states: IDLE, MUL1, MUL2, DONE.
REQ-015 IDLE: start=1 at an edge SHALL latch F, P_in and Qn_diag, clear ovf, set busy and enter MUL1. This edge is cycle 0.
REQ-016 MUL1, cycles 1..64: A[i][j] = sum_k F[i][k]*P[k][j]; one product per cycle; k innermost, then j, then i.
REQ-017 MUL2, cycles 65..128: R[i][j] = sum_k A[i][k]*F[j][k]; same loop order.
REQ-018 DONE, cycle 129: P_out SHALL be updated, done=1 for exactly that cycle, and busy=0. The FSM then returns to IDLE.
REQ-019 Fixed latency: the done edge SHALL come 129 cycles after the start edge.
REQ-020 Each product SHALL be the full 2N-bit signed result. The four products of one element accumulate in a 2N+2-bit accumulator.
REQ-021 Each accumulated sum SHALL be arithmetic-shifted right by Q (truncation toward minus infinity), then reduced to N bits per REQ-032/033.
REQ-022 In MUL2, Qn_diag[i] SHALL be added to diagonal elements after the shift and before reduction. Off-diagonal elements get no addition.
REQ-023 Intermediate A elements SHALL be stored as N-bit values using the same reduction rule.
REQ-024 start while busy SHALL be ignored. Latched inputs SHALL NOT change mid-computation.
REQ-025 start=1 on the same edge as DONE SHALL be ignored. A new start is accepted from IDLE only.
REQ-026 Input changes outside the start edge SHALL NOT affect the result.
REQ-027 P_out SHALL hold its value between done pulses.

Reset
REQ-028 While reset=1: state=IDLE, busy=0, done=0, ovf=0, P_out=0, and all accumulators and A storage cleared.
REQ-029 Reset mid-operation SHALL abort the computation with no done pulse, and P_out SHALL read 0.
REQ-030 The first start after reset deasserts SHALL behave as in REQ-015.

Configuration
REQ-031 Macro COV_SATURATE_EN selects the N-bit reduction rule.
REQ-032 With COV_SATURATE_EN defined: clamp out-of-range values to 2**(N-1)-1 or -2**(N-1), and set ovf.
REQ-033 Without COV_SATURATE_EN: keep the low N bits (two's-complement wrap), and set ovf whenever the discarded value differs from the true value.

Verification
REQ-034 F=I (diag 262144), P_in=I, Qn_diag=0, start at cycle 0 -> P_out=I, done only at cycle 129, busy high cycles 0..128, ovf=0.
REQ-035 F=I, P_in=I, Qn_diag all 256 -> P_out diagonal 262400, off-diagonal 0.
REQ-036 F=I except F[0][1]=131072, P_in=I, Qn=0 -> P_out[0][0]=327680, P_out[0][1]=P_out[1][0]=131072, P_out[1][1]=262144, all other off-diagonal 0.
REQ-037 F=100*I (26214400 diagonal), P_in=I -> diagonal 2147483647 with ovf=1 if COV_SATURATE_EN is defined, else -1673527296 with ovf=1.
REQ-038 Start at cycle 0, second start at cycle 40, reset pulse at cycle 90 -> second start ignored, no done, busy=0 and P_out=0 after reset; a following start yields the correct result at start+129.

Source files
------------

// File: rtl/covariance_predict.sv
// covariance_predict: P_out = F*P_in*F^T + diag(Qn_diag) in signed Q-format with one shared multiplier.
// Build option: define COV_SATURATE_EN to clamp out-of-range elements; otherwise they wrap to N bits.
module covariance_predict #(
    parameter int N = 32,
    parameter int Q = 18
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [16*N-1:0] F,
    input  logic [16*N-1:0] P_in,
    input  logic [4*N-1:0]  Qn_diag,
    output logic [16*N-1:0] P_out,
    output logic            busy,
    output logic            done,
    output logic            ovf
);
    typedef enum logic [1:0] {IDLE, MUL1, MUL2, DONE} state_t;

    state_t                 state;
    logic [5:0]             cnt;
    logic [1:0]             i, j, k;
    logic [16*N-1:0]        f_r, p_r, a_r, r_r;
    logic [4*N-1:0]         q_r;
    logic signed [2*N+1:0]  acc, sum, shifted, adj;
    logic signed [N-1:0]    op_a, op_b, qd;
    logic signed [2*N-1:0]  prod;
    logic [N:0]             red;

    // Reduce a wide value to N bits; the top bit of the result flags an out-of-range value.
    function automatic logic [N:0] reduce(input logic signed [2*N+1:0] v);
        logic fits;
        fits = (v[2*N+1:N-1] == {(N+3){v[N-1]}});
`ifdef COV_SATURATE_EN
        return fits ? {1'b0, v[N-1:0]} : {1'b1, v[2*N+1], {(N-1){~v[2*N+1]}}};
`else
        return {~fits, v[N-1:0]};
`endif
    endfunction

    assign k = cnt[1:0];
    assign j = cnt[3:2];
    assign i = cnt[5:4];

    // Operand selection, single multiply, accumulate, rescale, diagonal noise and reduction.
    always_comb begin
        op_a    = (state == MUL2) ? a_r[{i, k}*N +: N] : f_r[{i, k}*N +: N];
        op_b    = (state == MUL2) ? f_r[{j, k}*N +: N] : p_r[{k, j}*N +: N];
        prod    = op_a * op_b;
        sum     = acc + {{2{prod[2*N-1]}}, prod};
        shifted = sum >>> Q;
        qd      = q_r[i*N +: N];
        adj     = shifted + ((state == MUL2 && i == j) ? {{(N+2){qd[N-1]}}, qd} : '0);
        red     = reduce(adj);
    end

    // Control FSM and datapath state: one product per cycle, element written every fourth product.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
            f_r   <= '0;
            p_r   <= '0;
            q_r   <= '0;
            a_r   <= '0;
            r_r   <= '0;
            P_out <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    f_r   <= F;
                    p_r   <= P_in;
                    q_r   <= Qn_diag;
                    ovf   <= 1'b0;
                    busy  <= 1'b1;
                    cnt   <= '0;
                    acc   <= '0;
                    state <= MUL1;
                end
                MUL1, MUL2: begin
                    cnt <= cnt + 6'd1;
                    acc <= (k == 2'd3) ? '0 : sum;
                    if (k == 2'd3) begin
                        if (state == MUL1) a_r[{i, j}*N +: N] <= red[N-1:0];
                        else r_r[{i, j}*N +: N] <= red[N-1:0];
                        ovf <= ovf | red[N];
                    end
                    if (cnt == 6'd63) state <= (state == MUL1) ? MUL2 : DONE;
                end
                DONE: begin
                    P_out <= r_r;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_covariance_predict.sv
// tb_covariance_predict: directed vectors with a scoreboard queue and an independent done monitor.
module tb_covariance_predict;
    localparam int N   = 32;
    localparam int ONE = 262144;

    typedef struct {
        logic [16*N-1:0] p;
        logic            o;
        int              c;
        string           name;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [16*N-1:0] F = '0, P_in = '0;
    logic [4*N-1:0]  Qn_diag = '0;
    logic [16*N-1:0] P_out;
    logic            busy, done, ovf;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   st = 0;
    int   bcnt;
    exp_t sb[$];

    covariance_predict dut (
        .clk(clk), .reset(reset), .start(start), .F(F), .P_in(P_in),
        .Qn_diag(Qn_diag), .P_out(P_out), .busy(busy), .done(done), .ovf(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [16*N-1:0] diag(input logic [N-1:0] v);
        logic [16*N-1:0] m = '0;
        for (int d = 0; d < 4; d++) m[5*d*N +: N] = v;
        return m;
    endfunction

    function automatic logic [4*N-1:0] qvec(input logic [N-1:0] v);
        return {4{v}};
    endfunction

    task automatic check(input string name, input logic [16*N-1:0] got, input logic [16*N-1:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected result.
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (!reset && done) begin
            if (prev_done) check("done_width", 1, 0);
            if (sb.size() == 0) check("unexpected_done", 1, 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_P_out"}, P_out, e.p);
                check({e.name, "_ovf"}, {511'd0, ovf}, {511'd0, e.o});
                check({e.name, "_done_cycle"}, cyc - 1, e.c);
                check({e.name, "_busy_at_done"}, {511'd0, busy}, '0);
            end
        end
        prev_done <= done;
    end

    task automatic start_only(input logic [16*N-1:0] f, input logic [16*N-1:0] p, input logic [4*N-1:0] q);
        F = f; P_in = p; Qn_diag = q; start = 1'b1;
        @(posedge clk);
        st = cyc;
        #1 start = 1'b0;
    endtask

    task automatic issue(input string name, input logic [16*N-1:0] f, input logic [16*N-1:0] p,
                         input logic [4*N-1:0] q, input logic [16*N-1:0] want, input logic o);
        exp_t e;
        start_only(f, p, q);
        e.p = want; e.o = o; e.c = st + 129; e.name = name;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string name, output int busy_cycles);
        bit got = 0;
        busy_cycles = 0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if (done) got = 1;
            else if (busy) busy_cycles++;
        end
        if (!got) check({name, "_timeout"}, 1, 0);
        @(negedge clk);
    endtask

    logic [16*N-1:0] fi, f36, p36, f37, p37;
    logic [N-1:0]    sat_val;

    initial begin
        fi = diag(ONE);
        f36 = fi; f36[1*N +: N] = 131072;
        p36 = fi;
        p36[0*N +: N] = 327680; p36[1*N +: N] = 131072; p36[4*N +: N] = 131072;
        f37 = diag(26214400);
`ifdef COV_SATURATE_EN
        sat_val = 32'h7FFF_FFFF;
`else
        sat_val = 32'h9C40_0000;
`endif
        p37 = diag(sat_val);

        repeat (3) @(negedge clk);
        check("reset_busy", {511'd0, busy}, '0);
        check("reset_done", {511'd0, done}, '0);
        check("reset_ovf", {511'd0, ovf}, '0);
        check("reset_P_out", P_out, '0);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;

        issue("identity", fi, fi, '0, fi, 1'b0);
        wait_done("identity", bcnt);
        check("identity_busy_cycles", bcnt, 129);

        issue("noise", fi, fi, qvec(256), diag(262400), 1'b0);
        repeat (128) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("noise", bcnt);
        repeat (3) @(negedge clk);
        check("start_at_done_ignored", {511'd0, busy}, '0);

        issue("overflow", f37, fi, '0, p37, 1'b1);
        wait_done("overflow", bcnt);
        repeat (4) @(negedge clk);
        check("ovf_sticky", {511'd0, ovf}, {511'd0, 1'b1});

        issue("offdiag", f36, fi, '0, p36, 1'b0);
        wait_done("offdiag", bcnt);

        start_only(f36, fi, '0);
        repeat (39) @(posedge clk);
        #1 F = f37; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (49) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("abort_busy", {511'd0, busy}, '0);
        check("abort_P_out", P_out, '0);
        check("abort_ovf", {511'd0, ovf}, '0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (150) @(negedge clk);
        check("abort_no_result", P_out, '0);

        issue("after_abort", f36, fi, '0, p36, 1'b0);
        repeat (9) @(posedge clk);
        #1 F = f37; P_in = diag(7); Qn_diag = qvec(99);
        repeat (40) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("after_abort", bcnt);
        repeat (5) @(negedge clk);
        check("P_out_hold", P_out, p36);
        if (sb.size() != 0) check("missing_done", 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
